// File: rtl/clock_pkg.sv
// Shared state type and default key timing for the clock datapath's key conditioner.
// Autorepeat behaviour is selected with the KEY_AUTOREPEAT_EN macro.
package clock_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} key_state_t;

  // Without autorepeat, the FSM only needs to remember that the press strobe was sent.
  localparam key_state_t HELD = DELAY;

  localparam int CLK_HZ          = 50_000_000;
  localparam int DEBOUNCE_MS     = 20;
  localparam int REPEAT_DELAY_MS = 500;
  localparam int REPEAT_RATE_MS  = 100;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEF_DEBOUNCE_CYCLES     = ms_to_cycles(DEBOUNCE_MS);
  localparam int DEF_REPEAT_DELAY_CYCLES = ms_to_cycles(REPEAT_DELAY_MS);
  localparam int DEF_REPEAT_RATE_CYCLES  = ms_to_cycles(REPEAT_RATE_MS);

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, debounce counter and press/repeat strobe FSM.
// KEY_AUTOREPEAT_EN adds the DELAY/REPEAT timer; otherwise one strobe per press.
module key_channel
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYCLES = 10,
  parameter int REPEAT_RATE_CYCLES  = 3
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_pulse,
  output logic o_held
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_sync;
  logic            r_stable;
  logic [DB_W-1:0] r_db_cnt;
  key_state_t      r_state;
  logic            r_pulse;
  logic            w_diff;
  logic            w_flip;
  logic            w_press;
  logic            w_held_next;

  assign w_diff      = r_sync[1] ^ r_stable;
  assign w_flip      = w_diff && (r_db_cnt == DB_LAST);
  assign w_press     = w_flip && r_stable;
  assign w_held_next = ~(r_stable ^ w_flip);

  // r_stable is the accepted key level (1 = released), matching key_n polarity.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync   <= 2'b11;
      r_stable <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_sync   <= {r_sync[0], i_key_n};
      r_stable <= r_stable ^ w_flip;
      if (w_flip || !w_diff) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int DLY_W = $clog2(REPEAT_DELAY_CYCLES) + 1;
  localparam int RPT_W = $clog2(REPEAT_RATE_CYCLES) + 1;
  localparam int TMR_W = (DLY_W > RPT_W) ? DLY_W : RPT_W;
  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] RPT_LAST = TMR_W'(REPEAT_RATE_CYCLES - 1);

  logic [TMR_W-1:0] r_timer;

  // FSM acts on the next held level so a release wins over a coinciding expiry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pulse <= 1'b0;
      r_timer <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (!w_held_next) begin
        r_state <= IDLE;
        r_timer <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_press) begin
              r_pulse <= 1'b1;
              r_timer <= '0;
              r_state <= DELAY;
            end
          end
          DELAY: begin
            if (r_timer == DLY_LAST) begin
              r_pulse <= 1'b1;
              r_timer <= '0;
              r_state <= REPEAT;
            end else begin
              r_timer <= r_timer + TMR_W'(1);
            end
          end
          REPEAT: begin
            if (r_timer == RPT_LAST) begin
              r_pulse <= 1'b1;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + TMR_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (!w_held_next) begin
        r_state <= IDLE;
      end else if ((r_state == IDLE) && w_press) begin
        r_pulse <= 1'b1;
        r_state <= HELD;
      end
    end
  end
`endif

  assign o_pulse = r_pulse;
  assign o_held  = ~r_stable;

endmodule

// File: rtl/key_conditioner.sv
// Fans NUM_KEYS raw active-low buttons out to independent key_channel instances.
// Autorepeat is enabled by defining KEY_AUTOREPEAT_EN.
module key_conditioner
  import clock_pkg::*;
#(
  parameter int NUM_KEYS            = 3,
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] pulse,
  output logic [NUM_KEYS-1:0] held
);

  // An illegal configuration builds an inert block instead of a broken one.
  localparam bit PARAMS_OK = (NUM_KEYS >= 1) && (DEBOUNCE_CYCLES >= 2) &&
                             (REPEAT_DELAY_CYCLES >= 2) && (REPEAT_RATE_CYCLES >= 2);

  generate
    if (PARAMS_OK) begin : g_ok
      for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_channel #(
          .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
          ,
          .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
          .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
`endif
        ) u_key (
          .i_clk  (clk),
          .i_rst_n(rst),
          .i_key_n(key_n[gi]),
          .o_pulse(pulse[gi]),
          .o_held (held[gi])
        );
      end
    end else begin : g_bad
      assign pulse = '0;
      assign held  = '0;
    end
  endgenerate

endmodule
